// File: rtl/spi_regfile_peripheral.sv
// SPI mode-0 register-file peripheral: framed writes into a parametrised
// register bank, readback on cipo, write strobe and rejected-frame counter.
module spi_regfile_peripheral #(
  parameter int unsigned NUM_REGS    = 5,
  parameter int unsigned DATA_W      = 8,
  parameter int unsigned ADDR_W      = 7,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic                       i_clk,
  input  logic                       i_rst,
  input  logic                       i_cs_n,
  input  logic                       i_sclk,
  input  logic                       i_copi,
  output logic                       o_cipo,
  output logic                       o_cipo_oe,
  output logic [NUM_REGS*DATA_W-1:0] o_regs_out,
  output logic                       o_wr_stb,
  output logic [ADDR_W-1:0]          o_wr_addr,
  output logic [7:0]                 o_err_count
);

  localparam int unsigned FRAME_W = 1 + ADDR_W + DATA_W;
  localparam int unsigned CNT_W   = $clog2(FRAME_W + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ADDR,
    S_DATA,
    S_DONE,
    S_OVER
  } state_t;

  state_t r_state;
  state_t w_next;

  logic [SYNC_STAGES-1:0]     r_cs_sync;
  logic [SYNC_STAGES-1:0]     r_sclk_sync;
  logic [SYNC_STAGES-1:0]     r_copi_sync;
  logic                       r_cs_d;
  logic                       r_sclk_d;
  logic [CNT_W-1:0]           r_cnt;
  logic [FRAME_W-1:0]         r_shift;
  logic [DATA_W-1:0]          r_rd;
  logic [NUM_REGS*DATA_W-1:0] r_regs;
  logic                       r_wr_stb;
  logic [ADDR_W-1:0]          r_wr_addr;
  logic [7:0]                 r_err_count;

  logic              w_cs;
  logic              w_sclk;
  logic              w_copi;
  logic              w_cs_rise;
  logic              w_cs_fall;
  logic              w_sclk_rise;
  logic              w_sclk_fall;
  logic              w_shift_en;
  logic              w_rd_load;
  logic              w_rd_shift;
  logic              w_commit;
  logic              w_err;
  logic              w_restart;
  logic              w_fr_rw;
  logic [ADDR_W-1:0] w_fr_addr;
  logic [DATA_W-1:0] w_fr_data;
  logic              w_fr_ok;
  logic [ADDR_W-1:0] w_rd_addr;
  logic [DATA_W-1:0] w_rd_val;

  assign w_cs   = r_cs_sync[SYNC_STAGES-1];
  assign w_sclk = r_sclk_sync[SYNC_STAGES-1];
  assign w_copi = r_copi_sync[SYNC_STAGES-1];

  assign w_cs_rise   = w_cs & ~r_cs_d;
  assign w_cs_fall   = ~w_cs & r_cs_d;
  assign w_sclk_rise = w_sclk & ~r_sclk_d & ~w_cs;
  assign w_sclk_fall = ~w_sclk & r_sclk_d & ~w_cs;

  assign w_fr_rw   = r_shift[FRAME_W-1];
  assign w_fr_addr = r_shift[DATA_W +: ADDR_W];
  assign w_fr_data = r_shift[DATA_W-1:0];
  assign w_fr_ok   =
    ({{(32-ADDR_W){1'b0}}, w_fr_addr} < NUM_REGS);

  // Address as it stands once the last address bit is shifted in.
  assign w_rd_addr = ADDR_W'({r_shift, w_copi});

  always_comb begin
    w_rd_val = '0;
    for (int k = 0; k < NUM_REGS; k++) begin
      if (w_rd_addr == ADDR_W'(k))
        w_rd_val = r_regs[k*DATA_W +: DATA_W];
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_cs_sync   <= '1;
      r_sclk_sync <= '0;
      r_copi_sync <= '0;
      r_cs_d      <= 1'b1;
      r_sclk_d    <= 1'b0;
    end else begin
      r_cs_sync   <= {r_cs_sync[SYNC_STAGES-2:0], i_cs_n};
      r_sclk_sync <= {r_sclk_sync[SYNC_STAGES-2:0], i_sclk};
      r_copi_sync <= {r_copi_sync[SYNC_STAGES-2:0], i_copi};
      r_cs_d      <= w_cs;
      r_sclk_d    <= w_sclk;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next     = r_state;
    w_shift_en = 1'b0;
    w_rd_load  = 1'b0;
    w_rd_shift = 1'b0;
    w_commit   = 1'b0;
    w_err      = 1'b0;
    w_restart  = 1'b0;
    if (w_cs_rise) begin
      w_next = S_IDLE;
      case (r_state)
        S_DONE: begin
          w_commit = w_fr_ok & w_fr_rw;
          w_err    = ~w_fr_ok;
        end
        S_ADDR:  w_err = (r_cnt != '0);
        S_DATA:  w_err = 1'b1;
        S_OVER:  w_err = 1'b1;
        default: ;
      endcase
    end else if (w_cs_fall) begin
      w_next    = S_ADDR;
      w_restart = 1'b1;
    end else if (w_sclk_rise) begin
      case (r_state)
        S_ADDR: begin
          w_shift_en = 1'b1;
          if (r_cnt == CNT_W'(ADDR_W)) begin
            w_next    = S_DATA;
            w_rd_load = 1'b1;
          end
        end
        S_DATA: begin
          w_shift_en = 1'b1;
          if (r_cnt == CNT_W'(FRAME_W - 1))
            w_next = S_DONE;
        end
        S_DONE:  w_next = S_OVER;
        default: ;
      endcase
    end else if (w_sclk_fall && r_state == S_DATA
                 && r_cnt > CNT_W'(1 + ADDR_W)) begin
      // The fall right after the last address bit keeps the MSB on
      // cipo so the controller sees it at the first data rise.
      w_rd_shift = 1'b1;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_cnt       <= '0;
      r_shift     <= '0;
      r_rd        <= '0;
      r_regs      <= '0;
      r_wr_stb    <= 1'b0;
      r_wr_addr   <= '0;
      r_err_count <= '0;
    end else begin
      r_wr_stb <= 1'b0;
      if (w_restart) begin
        r_cnt   <= '0;
        r_shift <= '0;
        r_rd    <= '0;
      end
      if (w_shift_en) begin
        r_shift <= {r_shift[FRAME_W-2:0], w_copi};
        r_cnt   <= r_cnt + 1'b1;
      end
      if (w_rd_load)
        r_rd <= w_rd_val;
      else if (w_rd_shift)
        r_rd <= {r_rd[DATA_W-2:0], 1'b0};
      if (w_commit) begin
        for (int k = 0; k < NUM_REGS; k++) begin
          if (w_fr_addr == ADDR_W'(k))
            r_regs[k*DATA_W +: DATA_W] <= w_fr_data;
        end
        r_wr_addr <= w_fr_addr;
        r_wr_stb  <= 1'b1;
      end
      if (w_err && r_err_count != 8'hFF)
        r_err_count <= r_err_count + 8'd1;
    end
  end

  assign o_cipo_oe   = ~w_cs &
    (r_state == S_DATA || r_state == S_DONE);
  assign o_cipo      = o_cipo_oe & r_rd[DATA_W-1];
  assign o_regs_out  = r_regs;
  assign o_wr_stb    = r_wr_stb;
  assign o_wr_addr   = r_wr_addr;
  assign o_err_count = r_err_count;

endmodule
